// File: rtl/rca_accumulator.sv
// rca_accumulator: sums frames of operands arriving over a valid/ready stream
// using a ripple-carry adder (carry-in tied low), then presents the frame sum,
// a sticky carry-out and a saturating beat count over a second valid/ready
// handshake. Every output is driven straight from a register.
module rca_accumulator #(
    parameter int NUMBITS   = 8,
    parameter int COUNTBITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUMBITS-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUMBITS-1:0]   out_sum,
    output logic                 out_carry,
    output logic [COUNTBITS-1:0] out_count
);

    // S_WAIT is the post-reset state: one cycle before the input opens up.
    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic [COUNTBITS-1:0] COUNT_MAX = '1;

    state_e                 state_q,     state_d;
    logic [NUMBITS-1:0]     acc_q,       acc_d;
    logic                   carry_q,     carry_d;
    logic [COUNTBITS-1:0]   count_q,     count_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [NUMBITS-1:0]     out_sum_q,   out_sum_d;
    logic                   out_carry_q, out_carry_d;
    logic [COUNTBITS-1:0]   out_count_q, out_count_d;

    // Ripple-carry adder outputs.
    logic [NUMBITS-1:0]     add_result;
    logic                   add_carryout;

    // Frame-level running values, valid when a beat is accepted this cycle.
    logic                   accept;
    logic                   carry_next;
    logic [COUNTBITS-1:0]   count_next;

    // Ripple-carry adder: acc + in_data with carry-in fixed at 0, one full
    // adder per bit, carry rippling LSB to MSB through a loop-local variable.
    always_comb begin
        logic c;
        c          = 1'b0;
        add_result = '0;
        for (int i = 0; i < NUMBITS; i++) begin
            add_result[i] = acc_q[i] ^ in_data[i] ^ c;
            c             = (acc_q[i] & in_data[i]) | (c & (acc_q[i] ^ in_data[i]));
        end
        add_carryout = c;
    end

    assign accept     = in_valid && in_ready_q;
    assign carry_next = carry_q | add_carryout;
    // Count saturates at all-ones instead of wrapping back to zero.
    assign count_next = (count_q == COUNT_MAX) ? count_q : count_q + COUNTBITS'(1);

    // Next-state and registered-output logic for the three-state control FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_count_d = out_count_q;

        unique case (state_q)
            S_WAIT: begin
                state_d    = S_ACCUM;
                in_ready_d = 1'b1;
            end

            S_ACCUM: begin
                if (accept) begin
                    acc_d   = add_result;
                    carry_d = carry_next;
                    count_d = count_next;
                    if (in_last) begin
                        // Result is loaded on the same edge the last beat lands.
                        state_d     = S_HOLD;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_sum_d   = add_result;
                        out_carry_d = carry_next;
                        out_count_d = count_next;
                    end
                end
            end

            S_HOLD: begin
                // Input is closed; outputs stay put until downstream takes them.
                if (out_valid_q && out_ready) begin
                    state_d     = S_ACCUM;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    carry_d     = 1'b0;
                    count_d     = '0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d    = S_WAIT;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous active-low reset clears all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_WAIT;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, matching real flip-flop behaviour.
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_rca_accumulator.sv
// Bench for rca_accumulator: directed frames drive the input stream and push
// hand-computed results into a queue; a monitor pops and compares on each
// output handshake.
module tb_rca_accumulator;

    localparam int NUMBITS   = 8;
    localparam int COUNTBITS = 4;

    typedef struct packed {
        logic [NUMBITS-1:0]   sum;
        logic                 carry;
        logic [COUNTBITS-1:0] count;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUMBITS-1:0]   in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUMBITS-1:0]   out_sum;
    logic                 out_carry;
    logic [COUNTBITS-1:0] out_count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    rca_accumulator #(.NUMBITS(NUMBITS), .COUNTBITS(COUNTBITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare each accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_sum",   32'(out_sum),   32'(e.sum));
                check("out_carry", 32'(out_carry), 32'(e.carry));
                check("out_count", 32'(out_count), 32'(e.count));
            end
        end
    end

    // Drive one beat; waits (bounded) for in_ready, holds valid across one edge.
    task automatic send(input logic [NUMBITS-1:0] d, input logic last);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input logic [NUMBITS-1:0] s, input logic c, input logic [COUNTBITS-1:0] n);
        exp_t e;
        e.sum   = s;
        e.carry = c;
        e.count = n;
        sb.push_back(e);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(out_sum),   32'd0);
        check({tag, "_out_carry"}, 32'(out_carry), 32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 500) begin
            budget++;
            @(negedge clk);
        end
        check({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("wait_to_accum_in_ready", 32'(in_ready), 32'd1);

        // 1: 0x7F + 0x01 = 0x80, no carry.
        push(8'h80, 1'b0, 4'd2);
        send(8'h7F, 1'b0);
        send(8'h01, 1'b1);
        #1;
        check("t1_out_valid_after_last", 32'(out_valid), 32'd1);
        check("t1_in_ready_after_last",  32'(in_ready),  32'd0);
        drain("t1");

        // 2: 0xFF + 0x01 wraps to 0x00 with carry.
        push(8'h00, 1'b1, 4'd2);
        send(8'hFF, 1'b0);
        send(8'h01, 1'b1);
        drain("t2");

        // 3: carry from first add stays set through the frame.
        push(8'h1D, 1'b1, 4'd3);
        send(8'h7B, 1'b0);
        send(8'h92, 1'b0);
        send(8'h10, 1'b1);
        drain("t3");

        // 4: single beat held under backpressure; extra input ignored.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(8'h2E, 1'b0, 4'd1);
        send(8'h2E, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_out_valid", 32'(out_valid), 32'd1);
            check("t4_hold_out_sum",   32'(out_sum),   32'h2E);
            check("t4_hold_out_count", 32'(out_count), 32'd1);
            check("t4_hold_in_ready",  32'(in_ready),  32'd0);
            in_valid = 1'b1;
            in_data  = 8'h55;
            in_last  = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_release_out_valid", 32'(out_valid), 32'd0);
        check("t4_release_in_ready",  32'(in_ready),  32'd1);
        drain("t4");

        // 5: 20 beats of 0x01; count saturates at 15.
        push(8'h14, 1'b0, 4'd15);
        for (int i = 0; i < 20; i++) send(8'h01, (i == 19));
        drain("t5");

        // 6: reset mid-frame discards the partial sum.
        send(8'h40, 1'b0);
        send(8'h40, 1'b0);
        reset = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("t6_reset_held");
        reset = 1'b1;
        push(8'h05, 1'b0, 4'd1);
        send(8'h05, 1'b1);
        drain("t6");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
